// File: rtl/xm_uart_tx_fifo.sv
// rtl/xm_uart_tx_fifo.sv - byte FIFO and send sequencer feeding a UART transmitter
module xm_uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [7:0]        data_byte,
  output logic              send_en,
  input  logic              tx_done,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    GAP
  } state_t;

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_read;
  logic              do_write;
  logic [ADDR_W:0]   count_next;

  // A read is the sequencer picking up the head byte; a full FIFO still takes a write in that cycle
  always_comb begin
    do_read    = (state == IDLE) && !empty;
    do_write   = wr_en && (!full || do_read);
    count_next = count;
    if (do_write && !do_read) begin
      count_next = count + COUNT_ONE;
    end else if (do_read && !do_write) begin
      count_next = count - COUNT_ONE;
    end
  end

  // Storage array; contents are left alone on reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and flags, all derived from the same next count so they never disagree
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_read) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_next;
      full  <= (count_next == FULL_COUNT);
      empty <= (count_next == '0);
      if (wr_en && !do_write) begin
        overflow <= 1'b1;
      end
    end
  end

  // Send sequencer: load byte and pulse send_en, hold through the frame, then one gap cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data_byte <= 8'h00;
      send_en   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            data_byte <= mem[rd_ptr];
            send_en   <= 1'b1;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          send_en <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            state <= GAP;
          end
        end
        GAP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          send_en <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
